mem_req_arbiter: RTL and testbench
==================================

// Module: mem_req_arbiter
// PURPOSE
// Arbitrates the single memory port between the instruction fetcher (IC) and the load/store
// controller (LSC). Sits between both requesters and MemCtrl: latches one request at a time,
// drives MemCtrl with stable registered operands for the whole transaction and returns the
// result with a one-cycle done pulse. Data requests have priority; a starvation counter
// forces an instruction grant.
// PARAMETERS
// ADDR_WIDTH    32  address width
// DATA_WIDTH    32  load/store data width
// INST_WIDTH    32  instruction width
// STARVE_LIMIT  4   consecutive data grants while IC waits before IC is forced first
// PORTS
// clk_in            in   1   clock
// rst_in            in   1   reset, asynchronous, active-low
// rdy_in            in   1   global enable; low = freeze all state
// flush_in          in   1   ROB refresh; abort current transaction
// ic_req_in         in   1   IC request, held with stable addr until ic_done_out
// ic_addr_in        in   ADDR_WIDTH   fetch address
// ic_inst_out       out  INST_WIDTH   fetched instruction, valid with ic_done_out
// ic_done_out       out  1   one-cycle completion pulse to IC
// ls_req_in         in   1   LSC request, held with stable operands until ls_done_out
// ls_wr_in          in   1   1 = store, 0 = load
// ls_addr_in        in   ADDR_WIDTH   data address
// ls_len_in         in   3   bytes: 1, 2 or 4
// ls_data_in        in   DATA_WIDTH   store data
// ls_data_out       out  DATA_WIDTH   load data, zero-extended, valid with ls_done_out
// ls_done_out       out  1   one-cycle completion pulse to LSC
// mc_inst_req_out   out  1   to MemCtrl rdy_inst_ic_in
// mc_inst_addr_out  out  ADDR_WIDTH   to MemCtrl inst_addr_ic_in
// mc_inst_in        in   INST_WIDTH   from MemCtrl inst_ic_out
// mc_inst_done_in   in   1   from MemCtrl rdy_inst_ic_out
// mc_data_req_out   out  1   to MemCtrl rdy_data_lsc_in
// mc_wr_out         out  1   to MemCtrl wr_lsc_in
// mc_addr_out       out  ADDR_WIDTH   to MemCtrl addr_lsc_in
// mc_len_out        out  3   to MemCtrl len_lsc_in
// mc_data_s_out     out  DATA_WIDTH   to MemCtrl data_s_lsc_in
// mc_data_l_in      in   DATA_WIDTH   from MemCtrl data_l_lsc_out
// mc_data_done_in   in   1   from MemCtrl rdy_data_lsc_out
// BEHAVIOUR
// - Reset (rst_in=0, async): state IDLE, starve_cnt 0, all outputs and operand regs 0.
// - rdy_in=0: no state, counter or output change; pulses hold their value (bench keeps rdy_in high across pulses).
// - Priority per cycle: flush_in > rdy_in=0 > FSM. All outputs registered.
// - FSM states: IDLE, INST, DATA, GAP.
//   IDLE: if ls_req_in and !(ic_req_in && starve_cnt==STARVE_LIMIT) -> DATA; else if ic_req_in -> INST.
//     On grant, capture operands; mc_*_req_out high from the next cycle (1-cycle grant latency).
//   INST: hold mc_inst_req_out=1 and captured addr; on mc_inst_done_in: ic_inst_out<=mc_inst_in,
//     ic_done_out<=1, mc_inst_req_out<=0 -> GAP.
//   DATA: same with mc_data_* and ls_*; ls_data_out<=mc_data_l_in (also pulsed for stores).
//   GAP: one idle cycle with both mc requests low so MemCtrl returns to IDLE and the requester
//     drops its req; -> IDLE. Done pulses are exactly one cycle (cleared in GAP).
// - Never both mc_inst_req_out and mc_data_req_out high. Operands never change mid-transaction.
// - starve_cnt: +1 on each DATA grant while ic_req_in=1 (saturates at STARVE_LIMIT); cleared on INST grant
//   and on a DATA grant with ic_req_in=0.
// - flush_in=1 (rdy_in=1): -> IDLE, both mc requests 0, no done pulse, starve_cnt 0, late
//   mc_*_done_in ignored. System guarantees no committed store is in flight at flush.
// - Unexpected done (wrong state) is ignored. ls_len_in other than 1/2/4 is passed through untouched.
// TESTING
// - Lone fetch: ic_req_in=1, addr 0x1000, mem word 0x00112233 -> mc_inst_req_out at +1 cycle,
//   ic_done_out one cycle with ic_inst_out=0x00112233, then GAP, IDLE.
// - Simultaneous: ic_req_in and ls_req_in (load 0x2000, len 4) same cycle -> DATA granted first;
//   after ls_done_out+GAP, INST granted; requests never overlap.
// - Starvation: ic_req_in held, LSC issues back-to-back loads -> after 4 data grants the 5th
//   grant is INST even though ls_req_in=1; starve_cnt returns to 0.
// - Store byte: ls_wr_in=1, len 1, addr 0x30004, data 0xAB -> mc_wr_out=1, mc_len_out=1,
//   mc_data_s_out=0xAB stable until done; ls_done_out single pulse.
// - Flush mid-load: flush_in one cycle during DATA -> next cycle IDLE, requests 0, no ls_done_out
//   even if mc_data_done_in arrives the same/next cycle.
// - Async reset mid-INST and rdy_in=0 stall for 3 cycles -> outputs 0 immediately on reset;
//   during stall all outputs and state frozen, transaction resumes unchanged.

Source files
------------

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter
// Shares the single MemCtrl port between the instruction fetcher (IC) and the
// load/store controller (LSC). One request is latched at a time. MemCtrl sees
// stable, registered operands for the whole transaction. The result returns
// with a one-cycle done pulse, followed by one idle GAP cycle.
// Data requests win by default. A starvation counter forces an instruction
// grant once IC has waited through STARVE_LIMIT consecutive data grants.
//
// Ports
//   clk_in, rst_in (async, active-low), rdy_in (global enable), flush_in (abort)
//   ic_*   : fetch request/address in, instruction/done out
//   ls_*   : load/store request/operands in, load data/done out
//   mc_*   : MemCtrl side; registered request/operands out, results/done in
module mem_req_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned INST_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  flush_in,
  // instruction fetcher
  input  logic                  ic_req_in,
  input  logic [ADDR_WIDTH-1:0] ic_addr_in,
  output logic [INST_WIDTH-1:0] ic_inst_out,
  output logic                  ic_done_out,
  // load/store controller
  input  logic                  ls_req_in,
  input  logic                  ls_wr_in,
  input  logic [ADDR_WIDTH-1:0] ls_addr_in,
  input  logic [2:0]            ls_len_in,
  input  logic [DATA_WIDTH-1:0] ls_data_in,
  output logic [DATA_WIDTH-1:0] ls_data_out,
  output logic                  ls_done_out,
  // MemCtrl
  output logic                  mc_inst_req_out,
  output logic [ADDR_WIDTH-1:0] mc_inst_addr_out,
  input  logic [INST_WIDTH-1:0] mc_inst_in,
  input  logic                  mc_inst_done_in,
  output logic                  mc_data_req_out,
  output logic                  mc_wr_out,
  output logic [ADDR_WIDTH-1:0] mc_addr_out,
  output logic [2:0]            mc_len_out,
  output logic [DATA_WIDTH-1:0] mc_data_s_out,
  input  logic [DATA_WIDTH-1:0] mc_data_l_in,
  input  logic                  mc_data_done_in
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_LIMIT);

  typedef enum logic [1:0] {StIdle, StInst, StData, StGap} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       starve_q, starve_d;
  logic [INST_WIDTH-1:0] ic_inst_q, ic_inst_d;
  logic                  ic_done_q, ic_done_d;
  logic [DATA_WIDTH-1:0] ls_data_q, ls_data_d;
  logic                  ls_done_q, ls_done_d;
  logic                  mc_inst_req_q, mc_inst_req_d;
  logic [ADDR_WIDTH-1:0] mc_inst_addr_q, mc_inst_addr_d;
  logic                  mc_data_req_q, mc_data_req_d;
  logic                  mc_wr_q, mc_wr_d;
  logic [ADDR_WIDTH-1:0] mc_addr_q, mc_addr_d;
  logic [2:0]            mc_len_q, mc_len_d;
  logic [DATA_WIDTH-1:0] mc_data_s_q, mc_data_s_d;

  logic ic_forced;
  assign ic_forced = ic_req_in && (starve_q == StarveMax);

  always_comb begin
    state_d        = state_q;
    starve_d       = starve_q;
    ic_inst_d      = ic_inst_q;
    ic_done_d      = ic_done_q;
    ls_data_d      = ls_data_q;
    ls_done_d      = ls_done_q;
    mc_inst_req_d  = mc_inst_req_q;
    mc_inst_addr_d = mc_inst_addr_q;
    mc_data_req_d  = mc_data_req_q;
    mc_wr_d        = mc_wr_q;
    mc_addr_d      = mc_addr_q;
    mc_len_d       = mc_len_q;
    mc_data_s_d    = mc_data_s_q;

    if (flush_in) begin
      // Abort: any done arriving afterwards lands in IDLE and is ignored.
      state_d       = StIdle;
      starve_d      = '0;
      ic_done_d     = 1'b0;
      ls_done_d     = 1'b0;
      mc_inst_req_d = 1'b0;
      mc_data_req_d = 1'b0;
    end else if (rdy_in) begin
      unique case (state_q)
        StIdle: begin
          if (ls_req_in && !ic_forced) begin
            state_d       = StData;
            mc_data_req_d = 1'b1;
            mc_wr_d       = ls_wr_in;
            mc_addr_d     = ls_addr_in;
            mc_len_d      = ls_len_in;
            mc_data_s_d   = ls_data_in;
            if (!ic_req_in) begin
              starve_d = '0;
            end else if (starve_q != StarveMax) begin
              starve_d = starve_q + CntW'(1);
            end
          end else if (ic_req_in) begin
            state_d        = StInst;
            mc_inst_req_d  = 1'b1;
            mc_inst_addr_d = ic_addr_in;
            starve_d       = '0;
          end
        end
        StInst: begin
          if (mc_inst_done_in) begin
            state_d       = StGap;
            ic_inst_d     = mc_inst_in;
            ic_done_d     = 1'b1;
            mc_inst_req_d = 1'b0;
          end
        end
        StData: begin
          if (mc_data_done_in) begin
            state_d       = StGap;
            ls_data_d     = mc_data_l_in;
            ls_done_d     = 1'b1;
            mc_data_req_d = 1'b0;
          end
        end
        StGap: begin
          // Lets MemCtrl return to idle and the requester drop its req.
          state_d   = StIdle;
          ic_done_d = 1'b0;
          ls_done_d = 1'b0;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q        <= StIdle;
      starve_q       <= '0;
      ic_inst_q      <= '0;
      ic_done_q      <= 1'b0;
      ls_data_q      <= '0;
      ls_done_q      <= 1'b0;
      mc_inst_req_q  <= 1'b0;
      mc_inst_addr_q <= '0;
      mc_data_req_q  <= 1'b0;
      mc_wr_q        <= 1'b0;
      mc_addr_q      <= '0;
      mc_len_q       <= '0;
      mc_data_s_q    <= '0;
    end else begin
      state_q        <= state_d;
      starve_q       <= starve_d;
      ic_inst_q      <= ic_inst_d;
      ic_done_q      <= ic_done_d;
      ls_data_q      <= ls_data_d;
      ls_done_q      <= ls_done_d;
      mc_inst_req_q  <= mc_inst_req_d;
      mc_inst_addr_q <= mc_inst_addr_d;
      mc_data_req_q  <= mc_data_req_d;
      mc_wr_q        <= mc_wr_d;
      mc_addr_q      <= mc_addr_d;
      mc_len_q       <= mc_len_d;
      mc_data_s_q    <= mc_data_s_d;
    end
  end

  assign ic_inst_out      = ic_inst_q;
  assign ic_done_out      = ic_done_q;
  assign ls_data_out      = ls_data_q;
  assign ls_done_out      = ls_done_q;
  assign mc_inst_req_out  = mc_inst_req_q;
  assign mc_inst_addr_out = mc_inst_addr_q;
  assign mc_data_req_out  = mc_data_req_q;
  assign mc_wr_out        = mc_wr_q;
  assign mc_addr_out      = mc_addr_q;
  assign mc_len_out       = mc_len_q;
  assign mc_data_s_out    = mc_data_s_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter; the bench plays both requesters and MemCtrl.
module tb_mem_req_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        flush_in;
  logic        ic_req_in;
  logic [31:0] ic_addr_in;
  logic [31:0] ic_inst_out;
  logic        ic_done_out;
  logic        ls_req_in;
  logic        ls_wr_in;
  logic [31:0] ls_addr_in;
  logic [2:0]  ls_len_in;
  logic [31:0] ls_data_in;
  logic [31:0] ls_data_out;
  logic        ls_done_out;
  logic        mc_inst_req_out;
  logic [31:0] mc_inst_addr_out;
  logic [31:0] mc_inst_in;
  logic        mc_inst_done_in;
  logic        mc_data_req_out;
  logic        mc_wr_out;
  logic [31:0] mc_addr_out;
  logic [2:0]  mc_len_out;
  logic [31:0] mc_data_s_out;
  logic [31:0] mc_data_l_in;
  logic        mc_data_done_in;

  int total = 0;
  int bad   = 0;

  mem_req_arbiter #(
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (32),
    .INST_WIDTH  (32),
    .STARVE_LIMIT(4)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .rdy_in          (rdy_in),
    .flush_in        (flush_in),
    .ic_req_in       (ic_req_in),
    .ic_addr_in      (ic_addr_in),
    .ic_inst_out     (ic_inst_out),
    .ic_done_out     (ic_done_out),
    .ls_req_in       (ls_req_in),
    .ls_wr_in        (ls_wr_in),
    .ls_addr_in      (ls_addr_in),
    .ls_len_in       (ls_len_in),
    .ls_data_in      (ls_data_in),
    .ls_data_out     (ls_data_out),
    .ls_done_out     (ls_done_out),
    .mc_inst_req_out (mc_inst_req_out),
    .mc_inst_addr_out(mc_inst_addr_out),
    .mc_inst_in      (mc_inst_in),
    .mc_inst_done_in (mc_inst_done_in),
    .mc_data_req_out (mc_data_req_out),
    .mc_wr_out       (mc_wr_out),
    .mc_addr_out     (mc_addr_out),
    .mc_len_out      (mc_len_out),
    .mc_data_s_out   (mc_data_s_out),
    .mc_data_l_in    (mc_data_l_in),
    .mc_data_done_in (mc_data_done_in)
  );

  always #5 clk_in = ~clk_in;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0;
    ic_req_in = 1'b0; ic_addr_in = '0;
    ls_req_in = 1'b0; ls_wr_in = 1'b0; ls_addr_in = '0; ls_len_in = '0; ls_data_in = '0;
    mc_inst_in = '0; mc_inst_done_in = 1'b0; mc_data_l_in = '0; mc_data_done_in = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_inst_req", 32'(mc_inst_req_out), 32'd0);
    chk("rst_data_req", 32'(mc_data_req_out), 32'd0);
    chk("rst_ic_done", 32'(ic_done_out), 32'd0);
    chk("rst_ls_done", 32'(ls_done_out), 32'd0);
    chk("rst_mc_addr", mc_addr_out, 32'd0);
    rst_in = 1'b1;
    tick();

    // Lone fetch
    ic_req_in = 1'b1; ic_addr_in = 32'h1000;
    tick();
    chk("fetch_req", 32'(mc_inst_req_out), 32'd1);
    chk("fetch_addr", mc_inst_addr_out, 32'h1000);
    chk("fetch_no_data", 32'(mc_data_req_out), 32'd0);
    mc_inst_done_in = 1'b1; mc_inst_in = 32'h0011_2233;
    tick();
    chk("fetch_done", 32'(ic_done_out), 32'd1);
    chk("fetch_inst", ic_inst_out, 32'h0011_2233);
    chk("fetch_req_drop", 32'(mc_inst_req_out), 32'd0);
    mc_inst_done_in = 1'b0; ic_req_in = 1'b0;
    tick();
    chk("fetch_gap_done", 32'(ic_done_out), 32'd0);
    tick();
    chk("fetch_idle", 32'(mc_inst_req_out), 32'd0);

    // Simultaneous: data first, then instruction
    ic_req_in = 1'b1; ic_addr_in = 32'h1004;
    ls_req_in = 1'b1; ls_wr_in = 1'b0; ls_addr_in = 32'h2000; ls_len_in = 3'd4;
    tick();
    chk("sim_data_req", 32'(mc_data_req_out), 32'd1);
    chk("sim_no_inst", 32'(mc_inst_req_out), 32'd0);
    chk("sim_addr", mc_addr_out, 32'h2000);
    chk("sim_len", 32'(mc_len_out), 32'd4);
    chk("sim_wr", 32'(mc_wr_out), 32'd0);
    mc_data_done_in = 1'b1; mc_data_l_in = 32'hDEAD_BEEF;
    tick();
    chk("sim_ls_done", 32'(ls_done_out), 32'd1);
    chk("sim_ls_data", ls_data_out, 32'hDEAD_BEEF);
    chk("sim_data_drop", 32'(mc_data_req_out), 32'd0);
    mc_data_done_in = 1'b0; ls_req_in = 1'b0;
    tick();
    chk("sim_gap_ls_done", 32'(ls_done_out), 32'd0);
    chk("sim_gap_inst", 32'(mc_inst_req_out), 32'd0);
    tick();
    chk("sim_inst_req", 32'(mc_inst_req_out), 32'd1);
    chk("sim_inst_addr", mc_inst_addr_out, 32'h1004);
    chk("sim_inst_no_data", 32'(mc_data_req_out), 32'd0);
    mc_inst_done_in = 1'b1; mc_inst_in = 32'hCAFE_0001;
    tick();
    chk("sim_ic_done", 32'(ic_done_out), 32'd1);
    chk("sim_ic_inst", ic_inst_out, 32'hCAFE_0001);
    mc_inst_done_in = 1'b0; ic_req_in = 1'b0;
    tick();
    tick();

    // Starvation: four data grants while IC waits, then IC is forced
    ic_req_in = 1'b1; ic_addr_in = 32'h1008;
    ls_req_in = 1'b1; ls_addr_in = 32'h2100; ls_len_in = 3'd4;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("stv_data_req%0d", i), 32'(mc_data_req_out), 32'd1);
      chk($sformatf("stv_no_inst%0d", i), 32'(mc_inst_req_out), 32'd0);
      mc_data_done_in = 1'b1; mc_data_l_in = 32'(i + 16);
      tick();
      chk($sformatf("stv_ls_data%0d", i), ls_data_out, 32'(i + 16));
      mc_data_done_in = 1'b0;
      tick();
    end
    tick();
    chk("stv_forced_inst", 32'(mc_inst_req_out), 32'd1);
    chk("stv_forced_no_data", 32'(mc_data_req_out), 32'd0);
    mc_inst_done_in = 1'b1; mc_inst_in = 32'h0000_0BAD;
    tick();
    chk("stv_ic_done", 32'(ic_done_out), 32'd1);
    mc_inst_done_in = 1'b0;
    tick();
    // Counter cleared by the forced grant: data wins again with both requesting
    tick();
    chk("stv_cleared_data", 32'(mc_data_req_out), 32'd1);
    chk("stv_cleared_no_inst", 32'(mc_inst_req_out), 32'd0);
    mc_data_done_in = 1'b1;
    tick();
    mc_data_done_in = 1'b0; ls_req_in = 1'b0; ic_req_in = 1'b0;
    tick();
    tick();

    // Store byte with operand stability
    ls_req_in = 1'b1; ls_wr_in = 1'b1; ls_len_in = 3'd1;
    ls_addr_in = 32'h0003_0004; ls_data_in = 32'hAB;
    tick();
    chk("st_req", 32'(mc_data_req_out), 32'd1);
    chk("st_wr", 32'(mc_wr_out), 32'd1);
    chk("st_len", 32'(mc_len_out), 32'd1);
    chk("st_data", mc_data_s_out, 32'hAB);
    ls_data_in = 32'h55; ls_addr_in = 32'h9999;
    tick();
    chk("st_data_stable", mc_data_s_out, 32'hAB);
    chk("st_addr_stable", mc_addr_out, 32'h0003_0004);
    chk("st_no_done_yet", 32'(ls_done_out), 32'd0);
    mc_data_done_in = 1'b1; mc_data_l_in = 32'h0;
    tick();
    chk("st_done", 32'(ls_done_out), 32'd1);
    mc_data_done_in = 1'b0; ls_req_in = 1'b0; ls_wr_in = 1'b0;
    tick();
    chk("st_done_pulse", 32'(ls_done_out), 32'd0);
    tick();

    // Flush mid-load, with done arriving same and next cycle
    ls_req_in = 1'b1; ls_addr_in = 32'h4000; ls_len_in = 3'd2;
    tick();
    chk("fl_req", 32'(mc_data_req_out), 32'd1);
    flush_in = 1'b1; mc_data_done_in = 1'b1; mc_data_l_in = 32'h1234_5678;
    tick();
    chk("fl_req_drop", 32'(mc_data_req_out), 32'd0);
    chk("fl_no_done", 32'(ls_done_out), 32'd0);
    flush_in = 1'b0; ls_req_in = 1'b0;
    tick();
    chk("fl_late_done", 32'(ls_done_out), 32'd0);
    chk("fl_late_data", ls_data_out, 32'h0);
    mc_data_done_in = 1'b0;
    tick();

    // Stall for three cycles mid-INST, then resume
    ic_req_in = 1'b1; ic_addr_in = 32'h5000;
    tick();
    chk("stl_req", 32'(mc_inst_req_out), 32'd1);
    rdy_in = 1'b0; mc_inst_done_in = 1'b1; mc_inst_in = 32'h77;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stl_hold_req%0d", i), 32'(mc_inst_req_out), 32'd1);
      chk($sformatf("stl_hold_done%0d", i), 32'(ic_done_out), 32'd0);
      chk($sformatf("stl_hold_addr%0d", i), mc_inst_addr_out, 32'h5000);
    end
    rdy_in = 1'b1;
    tick();
    chk("stl_done", 32'(ic_done_out), 32'd1);
    chk("stl_inst", ic_inst_out, 32'h77);
    mc_inst_done_in = 1'b0; ic_req_in = 1'b0;
    tick();
    tick();

    // Async reset mid-INST
    ic_req_in = 1'b1; ic_addr_in = 32'h6000;
    tick();
    chk("ar_req", 32'(mc_inst_req_out), 32'd1);
    #2 rst_in = 1'b0;
    #1;
    chk("ar_req_zero", 32'(mc_inst_req_out), 32'd0);
    chk("ar_addr_zero", mc_inst_addr_out, 32'd0);
    chk("ar_inst_zero", ic_inst_out, 32'd0);
    ic_req_in = 1'b0;
    tick();
    rst_in = 1'b1;
    tick();
    chk("ar_idle", 32'(mc_inst_req_out), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
